// File: rtl/vad_hangover.sv
// Per-frame VAD decision smoother: onset confirmation followed by a hangover
// window, producing a registered speech flag with valid/rise/fall strobes.
module vad_hangover #(
    parameter int ONSET_FRAMES    = 3,
    parameter int HANGOVER_FRAMES = 8,
    parameter int CNT_W           = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic enable,
    input  logic clear,
    input  logic frame_valid,
    input  logic frame_result,
    output logic vad_out,
    output logic vad_valid,
    output logic vad_rise,
    output logic vad_fall
);

    localparam logic [1:0] SILENCE  = 2'd0;
    localparam logic [1:0] ONSET    = 2'd1;
    localparam logic [1:0] SPEECH   = 2'd2;
    localparam logic [1:0] HANGOVER = 2'd3;

    localparam logic [CNT_W:0]   ONSET_LIM = (CNT_W + 1)'(ONSET_FRAMES);
    localparam logic [CNT_W-1:0] HANG_LIM  = CNT_W'(HANGOVER_FRAMES);

    logic [1:0]       state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [CNT_W:0]   cnt_inc;
    logic             vad_out_reg, vad_valid_reg, vad_rise_reg, vad_fall_reg;
    logic             rise_next, fall_next;
    logic             accept;

    assign accept  = enable & ~clear & frame_valid;
    // One extra bit so the onset comparison cannot alias on a wrapped count.
    assign cnt_inc = {1'b0, cnt_reg} + (CNT_W + 1)'(1);

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        rise_next  = 1'b0;
        fall_next  = 1'b0;
        case (state_reg)
            SILENCE: begin
                if (frame_result) begin
                    if (ONSET_FRAMES == 1) begin
                        state_next = SPEECH;
                        cnt_next   = '0;
                        rise_next  = 1'b1;
                    end else begin
                        state_next = ONSET;
                        cnt_next   = CNT_W'(1);
                    end
                end else begin
                    cnt_next = '0;
                end
            end
            ONSET: begin
                if (frame_result) begin
                    if (cnt_inc == ONSET_LIM) begin
                        state_next = SPEECH;
                        cnt_next   = '0;
                        rise_next  = 1'b1;
                    end else begin
                        cnt_next = cnt_inc[CNT_W-1:0];
                    end
                end else begin
                    state_next = SILENCE;
                    cnt_next   = '0;
                end
            end
            SPEECH: begin
                if (!frame_result) begin
                    state_next = HANGOVER;
                    cnt_next   = CNT_W'(1);
                end
            end
            default: begin
                // HANGOVER: a speech frame silently resumes SPEECH
                if (frame_result) begin
                    state_next = SPEECH;
                    cnt_next   = '0;
                end else if (cnt_reg == HANG_LIM) begin
                    state_next = SILENCE;
                    cnt_next   = '0;
                    fall_next  = 1'b1;
                end else begin
                    cnt_next = cnt_inc[CNT_W-1:0];
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= SILENCE;
            cnt_reg       <= '0;
            vad_out_reg   <= 1'b0;
            vad_valid_reg <= 1'b0;
            vad_rise_reg  <= 1'b0;
            vad_fall_reg  <= 1'b0;
        end else if (clear) begin
            state_reg     <= SILENCE;
            cnt_reg       <= '0;
            vad_out_reg   <= 1'b0;
            vad_valid_reg <= 1'b0;
            vad_rise_reg  <= 1'b0;
            vad_fall_reg  <= 1'b0;
        end else if (accept) begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            vad_out_reg   <= (state_next == SPEECH) || (state_next == HANGOVER);
            vad_valid_reg <= 1'b1;
            vad_rise_reg  <= rise_next;
            vad_fall_reg  <= fall_next;
        end else begin
            vad_valid_reg <= 1'b0;
            vad_rise_reg  <= 1'b0;
            vad_fall_reg  <= 1'b0;
        end
    end

    assign vad_out   = vad_out_reg;
    assign vad_valid = vad_valid_reg;
    assign vad_rise  = vad_rise_reg;
    assign vad_fall  = vad_fall_reg;

endmodule

// File: doc/vad_hangover.md
# vad_hangover

Frame-level decision smoother placed directly downstream of the score comparator at the end of the BNN-VAD pipeline. Consumes the comparator's one-bit per-frame speech/non-speech result and applies onset confirmation plus hangover to produce a stable VAD flag with edge pulses. It suppresses isolated false positives and bridges short pauses inside speech.

## Interface
- ONSET_FRAMES, 3: consecutive speech frames required to declare speech; legal range 1..2^CNT_W-1.
- HANGOVER_FRAMES, 8: non-speech frames tolerated inside speech before release; legal range 1..2^CNT_W-1.
- CNT_W, 4: width of the shared frame counter.
- clk  input  1  system clock, all logic on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- enable  input  1  block enable; low = frames ignored, state held.
- clear  input  1  synchronous clear to SILENCE; has priority over frame_valid.
- frame_valid  input  1  one-cycle strobe: frame_result is valid this cycle.
- frame_result  input  1  comparator output; 1 = speech frame, 0 = non-speech.
- vad_out  output  1  smoothed VAD flag (registered level).
- vad_valid  output  1  one-cycle strobe, vad_out updated for the accepted frame.
- vad_rise  output  1  one-cycle pulse on 0->1 transition of vad_out.
- vad_fall  output  1  one-cycle pulse on 1->0 transition of vad_out.

## Operation
- A frame is accepted when enable=1, clear=0 and frame_valid=1. Nothing else changes state.
- States: SILENCE (vad_out=0), ONSET (vad_out=0), SPEECH (vad_out=1), HANGOVER (vad_out=1). Counter cnt is CNT_W bits.
- SILENCE: result=1 -> if ONSET_FRAMES=1, SPEECH with rise; else ONSET, cnt=1. result=0 -> stay, cnt=0.
- ONSET: result=1 -> if cnt+1=ONSET_FRAMES, SPEECH with rise, cnt=0; else cnt+1. result=0 -> SILENCE, cnt=0.
- SPEECH: result=1 -> stay. result=0 -> HANGOVER, cnt=1.
- HANGOVER: result=1 -> SPEECH, cnt=0, no pulses. result=0 -> if cnt=HANGOVER_FRAMES, SILENCE with fall, cnt=0; else cnt+1.
- Net effect: vad_out rises on the ONSET_FRAMES-th consecutive speech frame; falls on the (HANGOVER_FRAMES+1)-th consecutive non-speech frame.
- cnt never exceeds max(ONSET_FRAMES, HANGOVER_FRAMES); no wrap-around possible within legal parameters.
- clear: state=SILENCE, cnt=0, vad_out=0 next cycle; no vad_fall pulse, no vad_valid even if frame_valid is high.
- enable=0: frame_valid ignored, state/cnt/vad_out held, vad_valid/rise/fall forced 0.

## Timing
- Reset (rst_n=0, asynchronous): state=SILENCE, cnt=0, vad_out=0, vad_valid=0, vad_rise=0, vad_fall=0.
- Latency: frame accepted at edge N -> vad_out, vad_valid, vad_rise/vad_fall all valid after edge N+1 (one cycle), for exactly one cycle for the strobes.
- vad_rise and vad_fall are mutually exclusive and only asserted together with vad_valid.
- Back-to-back frame_valid on consecutive cycles fully supported; one decision per accepted frame, no stall.
- Reset release mid-stream: first accepted frame is evaluated from SILENCE.

## Test plan
- Reset: hold rst_n=0 with random inputs -> all outputs 0; release, frame_valid with result=0 -> vad_valid=1, vad_out=0.
- Onset: defaults, results 1,1,1 on consecutive strobes -> vad_out 0,0,1; vad_rise=1 only with 3rd vad_valid; pattern 1,1,0,1,1 -> vad_out stays 0.
- Hangover: from SPEECH, eight 0 frames -> vad_out stays 1; ninth 0 -> vad_out=0 with vad_fall=1; 0×5 then 1 -> returns to SPEECH, no pulses.
- Gaps/enable: frames spaced 4 cycles with enable toggling low on 2nd strobe -> that frame ignored, no vad_valid, onset needs one extra speech frame.
- Clear: in SPEECH, assert clear with frame_valid=1,result=1 -> vad_out=0 next cycle, no vad_valid, no vad_fall; next 3 speech frames re-trigger rise.
- Parameters: ONSET_FRAMES=1, HANGOVER_FRAMES=1 -> single 1 gives immediate rise; 0,0 gives fall on second 0.
